mult_unit: RTL and testbench

MULT_UNIT -- requirements
Module: mult_unit

---
 rtl/mult_unit_if.sv | 27 ++
 rtl/mult_unit.sv | 171 +++++++++++++++++
 tb/tb_mult_unit.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/mult_unit_if.sv
// Bus bundle for the iterative 32x32 multiplier (mult_unit).
// Carries the decoder request, the operand and mthi/mtlo write data, and
// the busy/done/hi/lo results. The clock and reset are plain ports on the
// multiplier and are not part of this bundle.
interface mult_unit_if;
  logic        start_mult;
  logic        mult_sign;
  logic [31:0] a;
  logic [31:0] b;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start_mult, mult_sign, a, b, hi_we, lo_we, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start_mult, mult_sign, a, b, hi_we, lo_we, wdata,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mult_unit.sv
// mult_unit: iterative radix-2 shift-add 32x32 -> 64 multiplier with hi/lo.
// Signed operands are reduced to magnitudes, and the product is negated at
// the end when the operand signs differ. Fixed latency is 32 RUN steps.
// Optional feature macro: MULT_EARLY_EXIT_EN -- finish RUN as soon as the
// remaining multiplier bits are all zero (minimum one step).
module mult_unit (
  input logic         clk,
  input logic         rst_n,
  mult_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic        w_accept;
  logic        w_step;
  logic        w_wr_en;
  logic        w_last;

  logic [63:0] r_mcand;
  logic [31:0] r_mplier;
  logic [63:0] r_acc;
  logic [5:0]  r_cnt;
  logic        r_neg;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_busy;
  logic        r_done;

  logic [63:0] w_acc_next;
  logic [31:0] w_mplier_next;
  logic [63:0] w_result;

  // Magnitude of a signed operand; 0x80000000 maps to itself, i.e. 2^31.
  function automatic logic [31:0] f_mag(input logic [31:0] v, input logic s);
    logic [31:0] m;
    if (s && v[31]) begin
      m = ~v + 32'd1;
    end else begin
      m = v;
    end
    return m;
  endfunction

  // Two's-complement negation over the full 64-bit product.
  function automatic logic [63:0] f_neg64(input logic [63:0] v);
    return ~v + 64'd1;
  endfunction

  assign w_acc_next    = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  assign w_mplier_next = {1'b0, r_mplier[31:1]};
  assign w_result      = r_neg ? f_neg64(w_acc_next) : w_acc_next;

`ifdef MULT_EARLY_EXIT_EN
  // Stop once no set multiplier bits remain; the counter bound is redundant
  // but keeps the step count capped at 32.
  assign w_last = (w_mplier_next == 32'd0) || (r_cnt == 6'd31);
`else
  assign w_last = (r_cnt == 6'd31);
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic plus the accept/step/write-enable strobes.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_step       = 1'b0;
    w_wr_en      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_wr_en = 1'b1;
        if (bus.start_mult) begin
          w_accept     = 1'b1;
          w_state_next = ST_RUN;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_RUN: begin
        w_step = 1'b1;
        if (w_last) begin
          w_state_next = ST_DONE;
        end else begin
          w_state_next = ST_RUN;
        end
      end
      ST_DONE: begin
        w_wr_en = 1'b1;
        if (bus.start_mult) begin
          w_accept     = 1'b1;
          w_state_next = ST_RUN;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Operand latch on accept, then one shift-add step per RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand  <= 64'd0;
      r_mplier <= 32'd0;
      r_acc    <= 64'd0;
      r_cnt    <= 6'd0;
      r_neg    <= 1'b0;
    end else if (w_accept) begin
      r_mcand  <= {32'd0, f_mag(bus.a, bus.mult_sign)};
      r_mplier <= f_mag(bus.b, bus.mult_sign);
      r_acc    <= 64'd0;
      r_cnt    <= 6'd0;
      r_neg    <= bus.mult_sign & (bus.a[31] ^ bus.b[31]);
    end else if (w_step) begin
      r_acc    <= w_acc_next;
      r_mcand  <= {r_mcand[62:0], 1'b0};
      r_mplier <= w_mplier_next;
      r_cnt    <= r_cnt + 6'd1;
    end
  end

  // hi/lo: the product on the final step, otherwise mthi/mtlo outside RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi <= 32'd0;
      r_lo <= 32'd0;
    end else if (w_step && w_last) begin
      r_hi <= w_result[63:32];
      r_lo <= w_result[31:0];
    end else begin
      if (w_wr_en && bus.hi_we) begin
        r_hi <= bus.wdata;
      end
      if (w_wr_en && bus.lo_we) begin
        r_lo <= bus.wdata;
      end
    end
  end

  // Status flags registered from the next state so they track the FSM exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (w_state_next == ST_RUN);
      r_done <= (w_state_next == ST_DONE);
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;

endmodule

// File: tb/tb_mult_unit.sv
// Self-checking bench for mult_unit: directed corner cases plus randomized
// operations compared against a plain-arithmetic reference product.
module tb_mult_unit;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_err;

  mult_unit_if u_if ();

  mult_unit u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference 64-bit product from ordinary integer arithmetic.
  function automatic logic [63:0] ref_prod(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint      sa;
    longint      sb;
    logic [63:0] ua;
    logic [63:0] ub;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end else begin
      ua = {32'd0, a};
      ub = {32'd0, b};
      return ua * ub;
    end
  endfunction

  // Expected number of RUN cycles between the start edge and done.
  function automatic int ref_lat(input logic sgn, input logic [31:0] b);
`ifdef MULT_EARLY_EXIT_EN
    logic [31:0] m;
    int          n;
    m = (sgn && b[31]) ? (32'd0 - b) : b;
    n = 1;
    for (int i = 0; i < 32; i++) begin
      if (m[i]) n = i + 1;
    end
    return n;
`else
    return 32;
`endif
  endfunction

  // Issue one multiply and check latency, busy window, hold of hi/lo and result.
  // With b2b set, the caller issues the next start while the unit is in DONE.
  task automatic do_mult(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input string tag, input bit b2b);
    logic [63:0] exp_p;
    logic [31:0] hold_hi;
    logic [31:0] hold_lo;
    int          lat;
    int          busy_cnt;
    bit          hold_bad;
    exp_p = ref_prod(sgn, a, b);
    lat   = ref_lat(sgn, b);
    u_if.start_mult = 1'b1;
    u_if.mult_sign  = sgn;
    u_if.a          = a;
    u_if.b          = b;
    tick();
    u_if.start_mult = 1'b0;
    u_if.a          = $urandom;
    u_if.b          = $urandom;
    hold_hi  = u_if.hi;
    hold_lo  = u_if.lo;
    busy_cnt = 0;
    hold_bad = 1'b0;
    for (int c = 0; c < 45; c++) begin
      if (u_if.done) break;
      if (u_if.busy) busy_cnt++;
      if (u_if.hi !== hold_hi || u_if.lo !== hold_lo) hold_bad = 1'b1;
      tick();
    end
    chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(lat));
    chk({tag, "_hold"}, 64'(hold_bad), 64'd0);
    chk({tag, "_done"}, 64'(u_if.done), 64'd1);
    chk({tag, "_busy_in_done"}, 64'(u_if.busy), 64'd0);
    chk({tag, "_prod"}, {u_if.hi, u_if.lo}, exp_p);
    if (!b2b) begin
      tick();
      chk({tag, "_done_drop"}, {62'd0, u_if.done, u_if.busy}, 64'd0);
    end
  endtask

  initial begin
    logic [63:0] p;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rs;
    int          lat;
    int          rst_edge;
    int          done_cnt;
    n_checks = 0;
    n_err    = 0;
    rst_n           = 1'b0;
    u_if.start_mult = 1'b0;
    u_if.mult_sign  = 1'b0;
    u_if.a          = 32'd0;
    u_if.b          = 32'd0;
    u_if.hi_we      = 1'b0;
    u_if.lo_we      = 1'b0;
    u_if.wdata      = 32'd0;

    // Reset state
    #2;
    chk("reset_state", {u_if.hi, u_if.lo}, 64'd0);
    chk("reset_flags", {62'd0, u_if.busy, u_if.done}, 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Directed corner cases
    do_mult(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "umax", 1'b0);
    do_mult(1'b1, 32'hFFFF_FFFD, 32'd5, "s_m3x5", 1'b0);
    chk("s_m3x5_abs", {u_if.hi, u_if.lo}, 64'hFFFF_FFFF_FFFF_FFF1);
    do_mult(1'b1, 32'h8000_0000, 32'h8000_0000, "smin", 1'b0);
    chk("smin_abs", {u_if.hi, u_if.lo}, 64'h4000_0000_0000_0000);
    do_mult(1'b1, 32'h8000_0000, 32'h0000_0003, "smin_x3", 1'b0);
    do_mult(1'b1, 32'hFFFF_FFFD, 32'd0, "s_neg_x0", 1'b0);

    // Ignored restart while running
    lat = ref_lat(1'b0, 32'd9);
    rst_edge = (lat > 5) ? 5 : lat - 1;
    u_if.start_mult = 1'b1; u_if.mult_sign = 1'b0; u_if.a = 32'd7; u_if.b = 32'd9;
    tick();
    u_if.start_mult = 1'b0;
    done_cnt = 0;
    for (int c = 1; c <= lat + 6; c++) begin
      if (c == rst_edge) begin
        u_if.start_mult = 1'b1; u_if.a = 32'd2; u_if.b = 32'd2;
      end else begin
        u_if.start_mult = 1'b0;
      end
      tick();
      if (u_if.done) done_cnt++;
    end
    chk("restart_ignored_prod", {u_if.hi, u_if.lo}, 64'h3F);
    chk("restart_one_done", 64'(done_cnt), 64'd1);

    // hi_we coinciding with start in IDLE
    u_if.hi_we = 1'b1; u_if.wdata = 32'hCAFE_0001;
    u_if.start_mult = 1'b1; u_if.mult_sign = 1'b0;
    u_if.a = 32'h0001_0000; u_if.b = 32'h8000_0001;
    tick();
    u_if.hi_we = 1'b0; u_if.start_mult = 1'b0;
    chk("hiwe_start_hi", 64'(u_if.hi), 64'hCAFE_0001);
    chk("hiwe_start_busy", 64'(u_if.busy), 64'd1);
    for (int c = 0; c < 45; c++) begin
      if (u_if.done) break;
      tick();
    end
    chk("hiwe_start_prod", {u_if.hi, u_if.lo}, ref_prod(1'b0, 32'h0001_0000, 32'h8000_0001));
    tick();

    // Write collisions: lo_we in RUN, on completion edge, and in IDLE
    p   = ref_prod(1'b0, 32'h1000, 32'h8000_0003);
    lat = ref_lat(1'b0, 32'h8000_0003);
    u_if.start_mult = 1'b1; u_if.a = 32'h1000; u_if.b = 32'h8000_0003;
    tick();
    u_if.start_mult = 1'b0;
    ra = u_if.lo;
    for (int c = 1; c <= lat; c++) begin
      u_if.lo_we = (c == 3 || c == lat);
      u_if.wdata = 32'h1234;
      tick();
      if (c == 3) chk("lowe_run_ignored", 64'(u_if.lo), 64'(ra));
    end
    u_if.lo_we = 1'b0;
    chk("lowe_completion_prod", {u_if.hi, u_if.lo}, p);
    tick();
    u_if.lo_we = 1'b1; u_if.wdata = 32'h1234;
    tick();
    u_if.lo_we = 1'b0;
    chk("lowe_idle_lo", 64'(u_if.lo), 64'h1234);
    chk("lowe_idle_hi", 64'(u_if.hi), {32'd0, p[63:32]});

    // Back-to-back: second start issued while in DONE
    do_mult(1'b1, 32'h7FFF_FFFF, 32'hFFFF_FFFF, "b2b_first", 1'b1);
    do_mult(1'b0, 32'hDEAD_BEEF, 32'h0000_0100, "b2b_second", 1'b0);

    // Reset in the middle of a run, then a fresh multiply
    u_if.start_mult = 1'b1; u_if.mult_sign = 1'b0;
    u_if.a = 32'h1234_5678; u_if.b = 32'h9ABC_DEF0;
    tick();
    u_if.start_mult = 1'b0;
    for (int c = 0; c < 9; c++) tick();
    chk("midrst_busy_before", 64'(u_if.busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_hilo", {u_if.hi, u_if.lo}, 64'd0);
    chk("midrst_flags", {62'd0, u_if.busy, u_if.done}, 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("midrst_stays_idle", {62'd0, u_if.busy, u_if.done}, 64'd0);
    do_mult(1'b0, 32'd6, 32'd7, "post_rst", 1'b0);
    chk("post_rst_lo", 64'(u_if.lo), 64'h2A);

    // Randomized operations
    for (int i = 0; i < 24; i++) begin
      rs = 1'($urandom_range(0, 1));
      ra = $urandom;
      rb = $urandom;
      if (i % 6 == 1) rb = rb & 32'h0000_00FF;
      if (i % 6 == 2) ra = 32'h8000_0000;
      if (i % 6 == 3) rb = 32'd1;
      do_mult(rs, ra, rb, "rand", 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
